// File: rtl/pe_group_feeder.sv
// Holds one operand tile and streams it into the PE group's weight, input and
// partial-sum channels, repeating the tile a latched number of passes.
module pe_group_feeder #(
  parameter int DataWidth = 32,
  parameter int W_Count   = 4,
  parameter int I_Count   = 7,
  parameter int O_Count   = 4,
  parameter int AddrWidth = 3
) (
  input  logic                 clk,
  input  logic                 aclr,
  input  logic                 LoadValid,
  output logic                 LoadRdy,
  input  logic [1:0]           LoadSel,
  input  logic [AddrWidth-1:0] LoadAddr,
  input  logic [DataWidth-1:0] LoadData,
  input  logic                 Start,
  input  logic [3:0]           Passes,
  output logic                 Busy,
  output logic                 Done,
  output logic                 W_DataOutValid,
  input  logic                 W_DataOutRdy,
  output logic [DataWidth-1:0] W_DataOut,
  output logic                 I_DataOutValid,
  input  logic                 I_DataOutRdy,
  output logic [DataWidth-1:0] I_DataOut,
  output logic                 O_DataOutValid,
  input  logic                 O_DataOutRdy,
  output logic [DataWidth-1:0] O_DataOut
);

  // top state | meaning
  // TOP_IDLE  | waiting for Start, loads allowed
  // TOP_RUN   | channels streaming, Busy = 1
  // TOP_DONE  | one-cycle Done pulse, channels return to idle
  // channel   | meaning
  // CH_IDLE   | no transfer
  // CH_SEND   | Valid high, word buffer[idx] offered
  // CH_FIN    | all passes sent, waiting for the other channels
  typedef enum logic [1:0] {TOP_IDLE, TOP_RUN, TOP_DONE} top_state_t;
  typedef enum logic [1:0] {CH_IDLE, CH_SEND, CH_FIN} ch_state_t;

  localparam int Depth = 1 << AddrWidth;

  function automatic int count_of(input int c);
    case (c)
      0:       count_of = W_Count;
      1:       count_of = I_Count;
      default: count_of = O_Count;
    endcase
  endfunction

  top_state_t top_q, top_d;
  ch_state_t  ch_q [3];
  ch_state_t  ch_d [3];
  logic [AddrWidth-1:0] idx_q [3];
  logic [AddrWidth-1:0] idx_d [3];
  logic [3:0] pass_q [3];
  logic [3:0] pass_d [3];
  logic [3:0] passes_q;
  logic [DataWidth-1:0] buf_q [3][Depth];
  logic [2:0] rdy;
  logic [2:0] valid;
  logic start_go;
  logic all_fin;
  logic load_en;

  assign rdy      = {O_DataOutRdy, I_DataOutRdy, W_DataOutRdy};
  assign Busy     = (top_q == TOP_RUN);
  assign Done     = (top_q == TOP_DONE);
  assign LoadRdy  = ~Busy;
  assign start_go = (top_q == TOP_IDLE) && Start;
  assign all_fin  = (ch_q[0] == CH_FIN) && (ch_q[1] == CH_FIN) && (ch_q[2] == CH_FIN);

  // Out-of-range and discard writes are still handshaken, just not stored.
  assign load_en = LoadValid && LoadRdy && (LoadSel != 2'd3) &&
                   (int'(LoadAddr) < count_of(int'(LoadSel)));

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      for (int c = 0; c < 3; c++)
        for (int a = 0; a < Depth; a++)
          buf_q[c][a] <= '0;
    end else if (load_en) begin
      buf_q[LoadSel][LoadAddr] <= LoadData;
    end
  end

  always_comb begin
    top_d = top_q;
    case (top_q)
      TOP_IDLE: if (Start) top_d = TOP_RUN;
      TOP_RUN:  if (all_fin) top_d = TOP_DONE;
      TOP_DONE: top_d = TOP_IDLE;
      default:  top_d = TOP_IDLE;
    endcase
  end

  always_comb begin
    for (int c = 0; c < 3; c++) begin
      ch_d[c]   = ch_q[c];
      idx_d[c]  = idx_q[c];
      pass_d[c] = pass_q[c];
      case (ch_q[c])
        CH_IDLE: begin
          if (start_go) begin
            ch_d[c]   = CH_SEND;
            idx_d[c]  = '0;
            pass_d[c] = '0;
          end
        end
        CH_SEND: begin
          if (rdy[c]) begin
            if (idx_q[c] == AddrWidth'(count_of(c) - 1)) begin
              idx_d[c]  = '0;
              pass_d[c] = pass_q[c] + 4'd1;
              if (pass_q[c] + 4'd1 == passes_q) ch_d[c] = CH_FIN;
            end else begin
              idx_d[c] = idx_q[c] + 1'b1;
            end
          end
        end
        CH_FIN: begin
          if (top_q == TOP_DONE) begin
            ch_d[c]   = CH_IDLE;
            pass_d[c] = '0;
          end
        end
        default: ch_d[c] = CH_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      top_q    <= TOP_IDLE;
      passes_q <= '0;
      for (int c = 0; c < 3; c++) begin
        ch_q[c]   <= CH_IDLE;
        idx_q[c]  <= '0;
        pass_q[c] <= '0;
      end
    end else begin
      top_q <= top_d;
      if (start_go) passes_q <= (Passes == 4'd0) ? 4'd1 : Passes;
      for (int c = 0; c < 3; c++) begin
        ch_q[c]   <= ch_d[c];
        idx_q[c]  <= idx_d[c];
        pass_q[c] <= pass_d[c];
      end
    end
  end

  always_comb begin
    for (int c = 0; c < 3; c++) valid[c] = (ch_q[c] == CH_SEND);
  end

  assign W_DataOutValid = valid[0];
  assign I_DataOutValid = valid[1];
  assign O_DataOutValid = valid[2];
  assign W_DataOut      = buf_q[0][idx_q[0]];
  assign I_DataOut      = buf_q[1][idx_q[1]];
  assign O_DataOut      = buf_q[2][idx_q[2]];

endmodule

// File: tb/tb_pe_group_feeder.sv
// Randomized bench for pe_group_feeder: a tile model plus per-channel expected
// word queues built from count x passes, checked at the falling edge.
module tb_pe_group_feeder;
  localparam int DW = 32;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          aclr = 1'b0;
  logic          load_valid = 1'b0;
  logic          load_rdy;
  logic [1:0]    load_sel = '0;
  logic [AW-1:0] load_addr = '0;
  logic [DW-1:0] load_data = '0;
  logic          start = 1'b0;
  logic [3:0]    passes = '0;
  logic          busy, done;
  logic [2:0]    vld;
  logic [2:0]    rdy = 3'b111;
  logic [DW-1:0] dat [3];

  pe_group_feeder dut (
    .clk(clk), .aclr(aclr),
    .LoadValid(load_valid), .LoadRdy(load_rdy), .LoadSel(load_sel),
    .LoadAddr(load_addr), .LoadData(load_data),
    .Start(start), .Passes(passes), .Busy(busy), .Done(done),
    .W_DataOutValid(vld[0]), .W_DataOutRdy(rdy[0]), .W_DataOut(dat[0]),
    .I_DataOutValid(vld[1]), .I_DataOutRdy(rdy[1]), .I_DataOut(dat[1]),
    .O_DataOutValid(vld[2]), .O_DataOutRdy(rdy[2]), .O_DataOut(dat[2])
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cnt [3] = '{4, 7, 4};
  logic [DW-1:0] mdl [3][8];
  logic [DW-1:0] exp_q [3][$];

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic clear_model();
    for (int c = 0; c < 3; c++)
      for (int a = 0; a < 8; a++) mdl[c][a] = '0;
  endtask

  // Called and returns at a falling edge.
  task automatic load_word(input int sel, input int addr, input logic [DW-1:0] data);
    load_valid = 1'b1;
    load_sel   = sel[1:0];
    load_addr  = addr[AW-1:0];
    load_data  = data;
    check_eq("load_rdy_idle", load_rdy, 1);
    if (sel != 3 && addr < cnt[sel]) mdl[sel][addr] = data;
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_done"}, done, 0);
    check_eq({tag, "_vld"}, vld, 0);
    check_eq({tag, "_ldrdy"}, load_rdy, 1);
    for (int c = 0; c < 3; c++) check_eq({tag, "_data"}, dat[c], 0);
  endtask

  // mode 0: all Rdy high; 1: I toggles 1,0,1,0; 2: random Rdy on every channel
  task automatic run_xfer(input int np, input int mode, input bit restart, input bit busy_loads);
    int p_eff;
    int last_hs;
    int done_cnt;
    bit empty;
    bit exp_busy, exp_done;
    bit prev_stall [3];
    logic [DW-1:0] prev_data [3];
    p_eff = (np == 0) ? 1 : np;
    last_hs = -10;
    done_cnt = 0;
    for (int c = 0; c < 3; c++) begin
      exp_q[c].delete();
      prev_stall[c] = 1'b0;
      prev_data[c] = '0;
      for (int p = 0; p < p_eff; p++)
        for (int k = 0; k < cnt[c]; k++) exp_q[c].push_back(mdl[c][k]);
    end
    start  = 1'b1;
    passes = np[3:0];
    @(negedge clk);
    passes = 4'($urandom_range(0, 15));
    for (int cyc = 1; cyc < 600; cyc++) begin
      case (mode)
        0: rdy = 3'b111;
        1: rdy = {1'b1, cyc[0], 1'b1};
        default: rdy = 3'($urandom_range(0, 7));
      endcase
      empty = (exp_q[0].size() == 0) && (exp_q[1].size() == 0) && (exp_q[2].size() == 0);
      exp_done = empty && (cyc == last_hs + 2);
      exp_busy = !(empty && (cyc >= last_hs + 2));
      check_eq("busy", busy, exp_busy);
      check_eq("done", done, exp_done);
      check_eq("load_rdy", load_rdy, !exp_busy);
      if (done) done_cnt++;
      start = restart && (cyc == 3 || exp_done);
      load_valid = busy_loads && exp_busy;
      load_sel   = 2'($urandom_range(0, 2));
      load_addr  = '0;
      load_data  = $urandom;
      for (int c = 0; c < 3; c++) begin
        if (cyc == 1) check_eq("valid_rise", vld[c], 1);
        if (prev_stall[c]) begin
          check_eq("stall_valid", vld[c], 1);
          check_eq("stall_data", dat[c], prev_data[c]);
        end
        if (vld[c] && rdy[c]) begin
          if (exp_q[c].size() == 0) begin
            check_eq("extra_word", vld[c], 0);
          end else begin
            check_eq("word", dat[c], exp_q[c].pop_front());
            if (exp_q[c].size() == 0) last_hs = cyc;
          end
        end
        prev_stall[c] = vld[c] && !rdy[c];
        prev_data[c]  = dat[c];
      end
      if (empty && cyc >= last_hs + 5) break;
      @(negedge clk);
    end
    start = 1'b0;
    load_valid = 1'b0;
    rdy = 3'b111;
    check_eq("done_count", done_cnt, 1);
    for (int c = 0; c < 3; c++) check_eq("words_left", exp_q[c].size(), 0);
  endtask

  initial begin
    clear_model();
    #2 aclr = 1'b1;
    #1 check_idle_outputs("reset");
    repeat (2) @(negedge clk);
    aclr = 1'b0;
    @(negedge clk);

    for (int k = 0; k < 4; k++) load_word(0, k, 10 + k);
    for (int k = 0; k < 7; k++) load_word(1, k, 20 + k);
    for (int k = 0; k < 4; k++) load_word(2, k, 30 + k);
    run_xfer(1, 0, 0, 0);
    run_xfer(2, 1, 0, 1);

    load_word(3, 2, 32'hdead);
    load_word(0, 5, 32'hbeef);
    run_xfer(0, 0, 1, 0);

    // Reset after two W handshakes
    rdy = 3'b111;
    start = 1'b1;
    passes = 4'd1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check_eq("pre_rst_w1", dat[0], mdl[0][1]);
    @(negedge clk);
    check_eq("pre_rst_wvld", vld[0], 1);
    check_eq("pre_rst_w2", dat[0], mdl[0][2]);
    aclr = 1'b1;
    #1 check_idle_outputs("midrun_rst");
    @(negedge clk);
    check_eq("rst_hold_done", done, 0);
    aclr = 1'b0;
    clear_model();
    @(negedge clk);
    check_idle_outputs("post_rst");
    run_xfer(1, 0, 0, 0);

    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 3; c++)
        for (int k = 0; k < cnt[c]; k++) load_word(c, k, $urandom);
      load_word(int'($urandom_range(0, 3)), int'($urandom_range(0, 7)), $urandom);
      run_xfer(int'($urandom_range(0, 3)), 2, 1'($urandom_range(0, 1)), 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
